// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin computed DIGIT bits per cycle, LSB digit first,
// with a registered borrow between digits and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;
    logic             r_done;

    logic [DIGIT-1:0] w_dig;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_last;

    // Operands shift right each digit, so the current digit is always in the low bits.
    always_comb begin : ripple
        logic v_bw;
        v_bw  = r_borrow;
        w_dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_dig[i] = r_a[i] ^ r_b[i] ^ v_bw;
            v_bw     = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & v_bw);
        end
        w_borrow_nxt = v_bw;
    end

    // New digit enters at the top; after NDIG shifts the first digit sits at bit 0.
    assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_dig) << (WIDTH - DIGIT));
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_a_msb  <= A[WIDTH-1];
                        r_b_msb  <= B[WIDTH-1];
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_borrow <= w_borrow_nxt;
                    r_res    <= w_res_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_d    <= w_res_nxt;
                        r_bout <= w_borrow_nxt;
                        r_v    <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign D    = r_d;
    assign Bout = r_bout;
    assign V    = r_v;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised multi-cycle N-bit subtractor built from a full-subtractor cell chain DIGIT bits wide, reused over WIDTH/DIGIT cycles, with a registered borrow between digits.
- Computes D = A - B - Bin, LSB digit first, with start/busy/done handshake.
- Successor to the single-bit combinational full subtractor. Used wherever area matters more than latency: datapath decrementers, comparators and accumulators in the combinational/sequential library.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- DIGIT, 1, bits processed per cycle. Must divide WIDTH. Elaboration error otherwise.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a subtraction; sampled on the rising clk edge.
- A, input, WIDTH, minuend.
- B, input, WIDTH, subtrahend.
- Bin, input, 1, borrow-in.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when the result is valid.
- D, output, WIDTH, difference A - B - Bin (mod 2^WIDTH).
- Bout, output, 1, final borrow-out. 1 when A < B + Bin (unsigned).
- V, output, 1, signed (two's-complement) overflow of the subtraction.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - busy=0, done=0, D=0, Bout=0, V=0.
  - Internal operand, borrow and digit-counter registers are cleared.
  - Takes effect immediately, not at the next edge.
  - Reset mid-operation aborts the operation: no done pulse, and D/Bout/V read 0.
- States: IDLE and RUN.
- IDLE:
  - On an edge with start=1, latch A, B and Bin, and set the internal borrow to Bin and the counter to 0.
  - busy=1 from that edge; state goes to RUN.
  - start=0 keeps the state in IDLE.
- RUN:
  - Each edge processes digit k = counter: bits [k*DIGIT+DIGIT-1 : k*DIGIT].
  - Uses a DIGIT-bit full-subtractor ripple with carry-in = the internal borrow.
  - Writes that digit of the result register, updates the borrow and increments the counter.
- Completion:
  - On the edge that processes the last digit (counter = WIDTH/DIGIT-1), update D with the full result and Bout with the final borrow.
  - V = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched operands.
  - Same edge: busy=0, done=1, state returns to IDLE.
- Latency: done is high exactly WIDTH/DIGIT cycles after the start edge. WIDTH=DIGIT gives 1 cycle.
- done is high for exactly one cycle and drops on the next edge.
- D, Bout and V hold their values until the next completion or reset.
- D, Bout and V do not change during RUN. Intermediate digits go to an internal register and are copied to D at completion.
- start while busy=1 is ignored: no restart and no re-latch. Operand changes during RUN have no effect.
- start=1 in the cycle done=1 (state already IDLE) is accepted. Back-to-back throughput is one result per WIDTH/DIGIT cycles.
- Bin=1 with A=B gives D = all ones and Bout=1.
- Arithmetic is modulo 2^WIDTH. Bout is the unsigned borrow and V the signed overflow, independent of each other.

Test Plan:
- WIDTH=8, DIGIT=1: start with A=0x35, B=0x12, Bin=0 -> busy=1 for 8 cycles; done pulses 8 cycles after the start edge; D=0x23, Bout=0, V=0.
- WIDTH=8, DIGIT=1: A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, V=0. Then A=0x80, B=0x01 -> D=0x7F, Bout=0, V=1. Then A=0x55, B=0x55, Bin=1 -> D=0xFF, Bout=1, V=0.
- Handshake: pulse start again 3 cycles into RUN with different operands -> ignored; first result is unchanged. Assert start in the done cycle -> the new operation begins; next done follows 8 cycles later.
- Reset: assert rst at cycle 4 of RUN, asynchronously between edges -> busy, done, D, Bout and V go to 0 immediately with no done pulse. A fresh start after release gives the correct result.
- WIDTH=8, DIGIT=4: A=0x10, B=0x01 -> done 2 cycles after start; D=0x0F, Bout=0. WIDTH=8, DIGIT=8 -> done 1 cycle after start.
- WIDTH=2, DIGIT=1: exhaustive over all 32 combinations of A, B and Bin -> D, Bout and V match the reference model {Bout, D} = A - B - Bin and the signed-overflow rule.
